// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, single-cycle response pulse after LATENCY edges.
// Optional out-of-range checking is compiled in with `define DMEM_RESP_BOUNDS_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_wren,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              wren_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_wdata;
  logic              eff_wren;
  logic              eff_oob;
  logic [IDX_W-1:0]  eff_idx;

  assign accept     = (state_q == S_IDLE) && req_ready_q && req_valid;
  assign enter_resp = (accept && (LATENCY == 1)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // With LATENCY = 1 the RESP entry coincides with the accept edge, so use the live request.
  assign eff_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign eff_wren  = (state_q == S_IDLE) ? req_wren  : wren_q;
  assign eff_idx   = eff_addr[IDX_W-1:0];

`ifdef DMEM_RESP_BOUNDS_CHECK_EN
  assign eff_oob = ({1'b0, eff_addr} >= (ADDR_W + 1)'(DEPTH));
`else
  logic unused_addr;
  assign eff_oob     = 1'b0;
  assign unused_addr = ^eff_addr;
`endif

  always_ff @(posedge clock) begin
    if (enter_resp && eff_wren && !eff_oob) begin
      mem_q[eff_idx] <= eff_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      wren_q      <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      if (enter_resp) begin
        state_q     <= S_RESP;
        req_ready_q <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= eff_oob;
        rsp_rdata_q <= (eff_wren || eff_oob) ? 32'd0 : mem_q[eff_idx];
      end else begin
        case (state_q)
          S_IDLE: begin
            req_ready_q <= ~accept;
            if (accept) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              wren_q  <= req_wren;
            end
          end
          S_WAIT: cnt_q <= cnt_q - 4'd1;
          S_RESP: begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
